popcount_acc: RTL and testbench

Streaming, pipelined population-count accumulator for the binary/low-precision datapath. It accepts one BW_I-bit word per cycle over a valid/ready handshake. Per beat it counts either the set bits of the word (plain mode) or the set bits of its XNOR with a weight word (binary dot-product mode). It accumulates these counts across a multi-beat vector delimited by a last flag and emits one saturated sum per vector. It sits between the activation/weight fetch stage and the threshold/requantisation stage.

---
 rtl/popcount_acc.sv | 156 +++++++++++++++
 tb/tb_popcount_acc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_acc.sv
// popcount_acc: streaming popcount / binary dot-product accumulator.
// Each accepted beat contributes popcount(i_data) or popcount(XNOR(i_data, i_weight)).
// The contributions are summed over a vector that ends on i_last, and one saturated sum
// is emitted per vector.
// Pipeline stages: S1 (popcount register) -> S2 (accumulator) -> output register.
// A single stall condition (output held, not consumed) freezes every stage.
module popcount_acc #(
  parameter int BW_I   = 16,
  parameter int BW_ACC = 12,
  parameter int BW_N   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [BW_I-1:0]   i_data,
  input  logic [BW_I-1:0]   i_weight,
  input  logic              i_mode,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BW_ACC-1:0] o_sum,
  output logic [BW_N-1:0]   o_nbeat,
  output logic              o_ovf
);

  // Width of a single-beat popcount (0..BW_I inclusive).
  localparam int PCW = $clog2(BW_I) + 1;
  localparam logic [BW_N-1:0] NB_ONE = {{(BW_N-1){1'b0}}, 1'b1};

  // Count of set bits in one word.
  function automatic logic [PCW-1:0] popcount(input logic [BW_I-1:0] w);
    logic [PCW-1:0] c;
    c = '0;
    for (int b = 0; b < BW_I; b++) begin
      c = c + {{(PCW-1){1'b0}}, w[b]};
    end
    return c;
  endfunction

  // Handshake / stall
  logic stall;
  logic accept;
  logic s2_fire;

  // Stage S1
  logic            s1_valid_q;
  logic            s1_last_q;
  logic [PCW-1:0]  s1_pc_q;
  logic [BW_I-1:0] sel_word;
  logic [PCW-1:0]  pc;

  // Stage S2 accumulator state
  logic [BW_ACC-1:0] acc_q;
  logic [BW_ACC-1:0] acc_d;
  logic [BW_N-1:0]   nb_q;
  logic [BW_N-1:0]   nb_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              first_q;

  // S2 arithmetic helpers
  logic [BW_ACC:0]   sum_w;
  logic              sat;
  logic [BW_N-1:0]   nb_base;

  // Output register
  logic              o_valid_q;
  logic [BW_ACC-1:0] o_sum_q;
  logic [BW_N-1:0]   o_nbeat_q;
  logic              o_ovf_q;

  // A held, unconsumed result freezes the whole pipe; i_ready follows o_ready combinationally.
  always_comb begin
    stall   = o_valid_q & ~o_ready;
    i_ready = ~stall;
    accept  = i_valid & ~stall;
    s2_fire = s1_valid_q & ~stall;
  end

  // Select the plain word or the XNOR with the weight, then count its ones.
  always_comb begin
    sel_word = i_mode ? ~(i_data ^ i_weight) : i_data;
    pc       = popcount(sel_word);
  end

  // S1: capture the beat's popcount and last flag; empty the stage when no beat arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pc_q    <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= i_last;
        s1_pc_q   <= pc;
      end
    end
  end

  // S2 next state: restart at vector start, saturate the sum, count beats with saturation.
  always_comb begin
    sum_w   = (first_q ? {(BW_ACC+1){1'b0}} : {1'b0, acc_q})
            + {{(BW_ACC+1-PCW){1'b0}}, s1_pc_q};
    // The wide sum never exceeds 2^(BW_ACC+1)-1, so the top bit flags overflow.
    sat     = sum_w[BW_ACC];
    acc_d   = sat ? {BW_ACC{1'b1}} : sum_w[BW_ACC-1:0];
    ovf_d   = (first_q ? 1'b0 : ovf_q) | sat;
    nb_base = first_q ? {BW_N{1'b0}} : nb_q;
    nb_d    = (&nb_base) ? nb_base : nb_base + NB_ONE;
  end

  // S2: commit accumulator state on each unstalled S1 beat; i_last re-arms vector start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      nb_q    <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else if (s2_fire) begin
      acc_q   <= acc_d;
      nb_q    <= nb_d;
      ovf_q   <= ovf_d;
      first_q <= s1_last_q;
    end
  end

  // Output register: load on a completed vector (even while the old result is being consumed).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_sum_q   <= '0;
      o_nbeat_q <= '0;
      o_ovf_q   <= 1'b0;
    end else if (!stall) begin
      if (s2_fire && s1_last_q) begin
        o_valid_q <= 1'b1;
        o_sum_q   <= acc_d;
        o_nbeat_q <= nb_d;
        o_ovf_q   <= ovf_d;
      end else if (o_ready) begin
        o_valid_q <= 1'b0;
      end
    end
  end

  // Drive the ports from the output register.
  always_comb begin
    o_valid = o_valid_q;
    o_sum   = o_sum_q;
    o_nbeat = o_nbeat_q;
    o_ovf   = o_ovf_q;
  end

endmodule

// File: tb/tb_popcount_acc.sv
// Testbench for popcount_acc: directed scenarios plus a randomized stream, checked against
// a vector-level reference model (sum of per-beat bit counts, clamped at the end).
module tb_popcount_acc;

  localparam int BW_I    = 16;
  localparam int BW_ACC  = 12;
  localparam int BW_N    = 8;
  localparam int SUM_MAX = (1 << BW_ACC) - 1;
  localparam int NB_MAX  = (1 << BW_N) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic [BW_I-1:0]   i_data;
  logic [BW_I-1:0]   i_weight;
  logic              i_mode;
  logic              i_last;
  logic              o_valid;
  logic              o_ready;
  logic [BW_ACC-1:0] o_sum;
  logic [BW_N-1:0]   o_nbeat;
  logic              o_ovf;

  popcount_acc #(.BW_I(BW_I), .BW_ACC(BW_ACC), .BW_N(BW_N)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_ready  (i_ready),
    .i_data   (i_data),
    .i_weight (i_weight),
    .i_mode   (i_mode),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_sum    (o_sum),
    .o_nbeat  (o_nbeat),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int nbeat;
    int ovf;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   errors    = 0;
  int   checks    = 0;
  int   cycles    = 0;
  int   stall_cnt = 0;
  int   raw_acc   = 0;
  int   beat_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: unclamped running total per vector, clamped only when the vector closes.
  task automatic model_beat();
    logic [BW_I-1:0] word;
    res_t r;
    word = i_mode ? ~(i_data ^ i_weight) : i_data;
    raw_acc += $countones(word);
    beat_cnt++;
    if (i_last) begin
      r.sum   = (raw_acc > SUM_MAX) ? SUM_MAX : raw_acc;
      r.nbeat = (beat_cnt > NB_MAX) ? NB_MAX : beat_cnt;
      r.ovf   = (raw_acc > SUM_MAX) ? 1 : 0;
      exp_q.push_back(r);
      raw_acc  = 0;
      beat_cnt = 0;
    end
  endtask

  task automatic check_out();
    res_t r;
    res_t e;
    r.sum   = int'(o_sum);
    r.nbeat = int'(o_nbeat);
    r.ovf   = int'(o_ovf);
    obs_q.push_back(r);
    check("pending_vector", (exp_q.size() > 0), 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_sum", r.sum, e.sum);
      check("sb_nbeat", r.nbeat, e.nbeat);
      check("sb_ovf", r.ovf, e.ovf);
      $display("vector %0d: sum=%0d nbeat=%0d ovf=%0d", obs_q.size(), r.sum, r.nbeat, r.ovf);
    end
  endtask

  // One clock: evaluate the handshakes the coming edge will see, then advance.
  task automatic tick();
    #1;
    check("i_ready", i_ready, !(o_valid && !o_ready));
    if (o_valid === 1'b1 && o_ready) check_out();
    if (i_valid && i_ready === 1'b1) model_beat();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic send_beat(input logic [BW_I-1:0] d, input logic [BW_I-1:0] w,
                           input logic m, input logic l);
    i_valid  = 1'b1;
    i_data   = d;
    i_weight = w;
    i_mode   = m;
    i_last   = l;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (i_ready) begin
        tick();
        i_valid = 1'b0;
        return;
      end
      stall_cnt++;
      tick();
    end
    check("send_accept", i_ready, 1'b1);
    i_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int target);
    for (int n = 0; n < 100 && obs_q.size() < target; n++) tick();
    check("out_count", obs_q.size(), target);
  endtask

  initial begin
    int base;
    int c0;

    // Reset state
    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_weight = '0; i_mode = 1'b0;
    i_last = 1'b0; o_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_sum", o_sum, 0);
    check("rst_o_nbeat", o_nbeat, 0);
    check("rst_o_ovf", o_ovf, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_i_ready", i_ready, 1'b1);
    tick();

    // Plain single beat with latency
    base = obs_q.size();
    send_beat(16'hFFFF, 16'h0000, 1'b0, 1'b1);
    check("lat_valid_k", o_valid, 1'b0);
    tick();
    check("lat_valid_k1", o_valid, 1'b1);
    check("plain_sum", o_sum, 16);
    check("plain_nbeat", o_nbeat, 1);
    check("plain_ovf", o_ovf, 1'b0);
    wait_outputs(base + 1);

    // XNOR single beat
    base = obs_q.size();
    send_beat(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
    wait_outputs(base + 1);
    check("xnor_sum", obs_q[base].sum, 8);

    // Back-to-back vectors A and B, no bubbles
    base = obs_q.size();
    stall_cnt = 0;
    c0 = cycles;
    send_beat(16'h0001, 16'h0000, 1'b0, 1'b0);
    send_beat(16'h0003, 16'h0000, 1'b0, 1'b0);
    send_beat(16'h0007, 16'h0000, 1'b0, 1'b1);
    send_beat(16'h8000, 16'h0000, 1'b0, 1'b1);
    check("ab_cycles", cycles - c0, 4);
    check("ab_no_stall", stall_cnt, 0);
    wait_outputs(base + 2);
    check("a_sum", obs_q[base].sum, 6);
    check("a_nbeat", obs_q[base].nbeat, 3);
    check("b_sum", obs_q[base+1].sum, 1);
    check("b_nbeat", obs_q[base+1].nbeat, 1);

    // Saturation over 300 beats, then a clean vector
    base = obs_q.size();
    for (int n = 1; n <= 300; n++) send_beat(16'hFFFF, 16'h0000, 1'b0, (n == 300));
    send_beat(16'h0003, 16'h0000, 1'b0, 1'b1);
    wait_outputs(base + 2);
    check("sat_sum", obs_q[base].sum, 4095);
    check("sat_ovf", obs_q[base].ovf, 1);
    check("sat_nbeat", obs_q[base].nbeat, 255);
    check("post_sat_sum", obs_q[base+1].sum, 2);
    check("post_sat_ovf", obs_q[base+1].ovf, 0);

    // Backpressure
    base = obs_q.size();
    o_ready = 1'b0;
    send_beat(16'h000F, 16'h0000, 1'b0, 1'b1);
    send_beat(16'h00FF, 16'h0000, 1'b0, 1'b1);
    check("bp_o_valid", o_valid, 1'b1);
    check("bp_i_ready_drop", i_ready, 1'b0);
    check("bp_sum_first", o_sum, 4);
    repeat (3) tick();
    check("bp_hold_valid", o_valid, 1'b1);
    check("bp_hold_sum", o_sum, 4);
    check("bp_hold_ready", i_ready, 1'b0);
    o_ready = 1'b1;
    wait_outputs(base + 2);
    check("bp_out0", obs_q[base].sum, 4);
    check("bp_out1", obs_q[base+1].sum, 8);

    // Randomized stream with random backpressure
    for (int n = 0; n < 600; n++) begin
      i_valid  = ($urandom_range(0, 3) != 0);
      i_data   = 16'($urandom);
      i_weight = 16'($urandom);
      i_mode   = 1'($urandom);
      i_last   = ($urandom_range(0, 4) == 0);
      o_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() > 0; n++) tick();
    check("rand_drained", exp_q.size(), 0);

    // Reset mid-vector
    send_beat(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    send_beat(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_sum", o_sum, 0);
    check("mid_rst_nbeat", o_nbeat, 0);
    check("mid_rst_ovf", o_ovf, 1'b0);
    raw_acc  = 0;
    beat_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = obs_q.size();
    send_beat(16'h0001, 16'h0000, 1'b0, 1'b1);
    wait_outputs(base + 1);
    check("post_rst_sum", obs_q[base].sum, 1);
    check("post_rst_nbeat", obs_q[base].nbeat, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
